// File: rtl/dsp_addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dsp_addsub_arbiter_if
// Brief    : Bundle of requester handshakes, shared result, grant counters
//            and the register-driven link to the combinational add/sub dsp.
//            The slave modport is the arbiter's view; the master modport is
//            the view of the requesters plus the dsp block.
// Revision : 1.0  initial release
// ============================================================================
interface dsp_addsub_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    // Requester side
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] b1;
    logic             sub0;
    logic             sub1;
    logic             ack0;
    logic             ack1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             busy;

    // dsp side
    logic [WIDTH-1:0] dsp_in1;
    logic [WIDTH-1:0] dsp_in2;
    logic             dsp_addorsub;
    logic [WIDTH-1:0] dsp_out;

    // Grant statistics
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    modport slave (
        input  req0, req1, a0, a1, b0, b1, sub0, sub1, dsp_out,
        output ack0, ack1, done0, done1, result, busy,
        output dsp_in1, dsp_in2, dsp_addorsub, gnt_cnt0, gnt_cnt1
    );

    modport master (
        output req0, req1, a0, a1, b0, b1, sub0, sub1, dsp_out,
        input  ack0, ack1, done0, done1, result, busy,
        input  dsp_in1, dsp_in2, dsp_addorsub, gnt_cnt0, gnt_cnt1
    );
endinterface
`default_nettype wire

// File: rtl/dsp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dsp_addsub_arbiter
// Brief    : Shares one combinational 32-bit add/sub dsp between two
//            requesters. Accepts a request in IDLE, drives the dsp from
//            registered operands during EXEC, captures the dsp output and
//            pulses done to the owning requester in DONE (3 cycles per op).
//            Build option DSP_ARB_RR_EN: round-robin on ties (req0 wins the
//            first tie after reset); otherwise fixed priority to req0.
// Revision : 1.0  initial release
// ============================================================================
module dsp_addsub_arbiter #(
    // Must stay 32: the dsp splits each operand into two 16-bit halves.
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    dsp_addsub_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [WIDTH-1:0] r_in1;
    logic [WIDTH-1:0] r_in2;
    logic             r_sub;
    logic [WIDTH-1:0] r_result;
    logic             r_owner;
    logic             r_done0;
    logic             r_done1;
    logic             r_busy;
    logic [CNT_W-1:0] r_gnt_cnt0;
    logic [CNT_W-1:0] r_gnt_cnt1;
`ifdef DSP_ARB_RR_EN
    // Most recently granted requester; the other one wins the next tie.
    logic             r_last;
`endif

    logic             w_any_req;
    logic             w_win;      // 0 = requester 0, 1 = requester 1
    logic             w_idle;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_op_sub;

    assign w_idle = (r_state == S_IDLE);

    // Arbitration: choose which requester would be granted this cycle.
    always_comb begin
        w_any_req = bus.req0 | bus.req1;
`ifdef DSP_ARB_RR_EN
        if (bus.req0 && bus.req1) begin
            w_win = ~r_last;
        end else begin
            w_win = bus.req1;
        end
`else
        w_win = ~bus.req0;
`endif
    end

    // Operand select for the winning requester.
    always_comb begin
        w_op_a   = w_win ? bus.a1   : bus.a0;
        w_op_b   = w_win ? bus.b1   : bus.b0;
        w_op_sub = w_win ? bus.sub1 : bus.sub0;
    end

    // Control FSM with registered operands, result, done pulses and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in1      <= '0;
            r_in2      <= '0;
            r_sub      <= 1'b0;
            r_result   <= '0;
            r_owner    <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_busy     <= 1'b0;
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
`ifdef DSP_ARB_RR_EN
            r_last     <= 1'b1;
`endif
        end else begin
            // done is a single-cycle pulse; only the EXEC->DONE step raises it.
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_in1   <= w_op_a;
                        r_in2   <= w_op_b;
                        r_sub   <= w_op_sub;
                        r_owner <= w_win;
`ifdef DSP_ARB_RR_EN
                        r_last  <= w_win;
`endif
                        if (w_win) begin
                            if (r_gnt_cnt1 != C_CNT_MAX) begin
                                r_gnt_cnt1 <= r_gnt_cnt1 + CNT_W'(1);
                            end
                        end else begin
                            if (r_gnt_cnt0 != C_CNT_MAX) begin
                                r_gnt_cnt0 <= r_gnt_cnt0 + CNT_W'(1);
                            end
                        end
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // dsp has had a full cycle of stable registered inputs.
                    r_result <= bus.dsp_out;
                    r_done0  <= ~r_owner;
                    r_done1  <= r_owner;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Acks are combinational and only ever asserted in IDLE.
    assign bus.ack0         = w_idle & w_any_req & ~w_win;
    assign bus.ack1         = w_idle & w_any_req &  w_win;
    assign bus.done0        = r_done0;
    assign bus.done1        = r_done1;
    assign bus.result       = r_result;
    assign bus.busy         = r_busy;
    assign bus.dsp_in1      = r_in1;
    assign bus.dsp_in2      = r_in2;
    assign bus.dsp_addorsub = r_sub;
    assign bus.gnt_cnt0     = r_gnt_cnt0;
    assign bus.gnt_cnt1     = r_gnt_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_dsp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_addsub_arbiter
// Brief    : Self-checking bench for dsp_addsub_arbiter with a transaction
//            level reference model and directed scenarios. A second instance
//            with 2-bit grant counters exercises counter saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_dsp_addsub_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int C_GMAX = 65535;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    dsp_addsub_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    dsp_addsub_arbiter_if #(.WIDTH(WIDTH), .CNT_W(2))     bus2 ();

    dsp_addsub_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dsp_addsub_arbiter #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    // Combinational dsp: mod-2^32 add or subtract.
    assign bus.dsp_out  = bus.dsp_addorsub  ? bus.dsp_in1  - bus.dsp_in2  : bus.dsp_in1  + bus.dsp_in2;
    assign bus2.dsp_out = bus2.dsp_addorsub ? bus2.dsp_in1 - bus2.dsp_in2 : bus2.dsp_in1 + bus2.dsp_in2;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one op = 3 cycles) ----------------
    int          m_phase;   // 0 idle, 2 operating on operands, 1 result delivered
    int          m_owner;
    logic [31:0] m_a, m_b, m_result;
    logic        m_sub;
    int          m_g0, m_g1;
`ifdef DSP_ARB_RR_EN
    int          m_last;
`endif

    function automatic int pick(input logic r0, input logic r1);
`ifdef DSP_ARB_RR_EN
        if (r0 && r1) return (m_last == 1) ? 0 : 1;
`endif
        return r0 ? 0 : 1;
    endfunction

    function automatic logic exp_ack(input int id);
        return (m_phase == 0) && (bus.req0 || bus.req1) && (pick(bus.req0, bus.req1) == id);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= 0;
            m_owner  <= 0;
            m_a      <= '0;
            m_b      <= '0;
            m_sub    <= 1'b0;
            m_result <= '0;
            m_g0     <= 0;
            m_g1     <= 0;
`ifdef DSP_ARB_RR_EN
            m_last   <= 1;
`endif
        end else if (m_phase == 0) begin
            if (bus.req0 || bus.req1) begin
                if (pick(bus.req0, bus.req1) == 0) begin
                    m_a <= bus.a0; m_b <= bus.b0; m_sub <= bus.sub0; m_owner <= 0;
                    m_g0 <= (m_g0 == C_GMAX) ? m_g0 : m_g0 + 1;
`ifdef DSP_ARB_RR_EN
                    m_last <= 0;
`endif
                end else begin
                    m_a <= bus.a1; m_b <= bus.b1; m_sub <= bus.sub1; m_owner <= 1;
                    m_g1 <= (m_g1 == C_GMAX) ? m_g1 : m_g1 + 1;
`ifdef DSP_ARB_RR_EN
                    m_last <= 1;
`endif
                end
                m_phase <= 2;
            end
        end else if (m_phase == 2) begin
            m_result <= m_sub ? (m_a - m_b) : (m_a + m_b);
            m_phase  <= 1;
        end else begin
            m_phase <= 0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_ack0",   64'(bus.ack0),  64'(exp_ack(0)));
            check("m_ack1",   64'(bus.ack1),  64'(exp_ack(1)));
            check("m_busy",   64'(bus.busy),  64'(m_phase != 0));
            check("m_done0",  64'(bus.done0), 64'(m_phase == 1 && m_owner == 0));
            check("m_done1",  64'(bus.done1), 64'(m_phase == 1 && m_owner == 1));
            check("m_result", 64'(bus.result), 64'(m_result));
            check("m_in1",    64'(bus.dsp_in1), 64'(m_a));
            check("m_in2",    64'(bus.dsp_in2), 64'(m_b));
            check("m_aos",    64'(bus.dsp_addorsub), 64'(m_sub));
            check("m_gnt0",   64'(bus.gnt_cnt0), 64'(m_g0));
            check("m_gnt1",   64'(bus.gnt_cnt1), 64'(m_g1));
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp, input string name);
        int n;
        @(posedge clk); #1;
        if (r == 0) begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.sub0 = s; end
        else        begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.sub1 = s; end
        n = 0;
        @(negedge clk);
        while (!((r == 0) ? bus.ack0 : bus.ack1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ack_wait"}, 64'(n < 20), 64'd1);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);                       // T+1
        check({name, "_busy_t1"}, 64'(bus.busy), 64'd1);
        check({name, "_done_t1"}, 64'(bus.done0 | bus.done1), 64'd0);
        @(negedge clk);                       // T+2
        check({name, "_done_own"}, 64'((r == 0) ? bus.done0 : bus.done1), 64'd1);
        check({name, "_done_oth"}, 64'((r == 0) ? bus.done1 : bus.done0), 64'd0);
        check({name, "_result"},   64'(bus.result), 64'(exp));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int ack_id[$];
    int ack_cyc[$];
    int exp_id[4];
    int nacks;

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.sub0 = 1'b0; bus.sub1 = 1'b0;
        bus2.req0 = 1'b0; bus2.req1 = 1'b0;
        bus2.a0 = '0; bus2.b0 = '0; bus2.a1 = '0; bus2.b1 = '0;
        bus2.sub0 = 1'b0; bus2.sub1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst2 = 1'b0;
        cmp_en = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_busy",   64'(bus.busy), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_done",   64'({bus.done0, bus.done1}), 64'd0);
        check("rst_ack",    64'({bus.ack0, bus.ack1}), 64'd0);
        check("rst_dsp",    64'({bus.dsp_in1, bus.dsp_in2, bus.dsp_addorsub} != '0), 64'd0);
        check("rst_gnt",    64'({bus.gnt_cnt0, bus.gnt_cnt1}), 64'd0);

        // Basic add/sub, wraparound
        do_op(0, 32'd5, 32'd3, 1'b0, 32'd8, "add5p3");
        check("gnt0_after1", 64'(bus.gnt_cnt0), 64'd1);
        do_op(1, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, "sub3m5");
        do_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, "wrap_add");
        do_op(0, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, "wrap_sub");
        check("gnt1_after2", 64'(bus.gnt_cnt1), 64'd2);

        // req1 raised during EXEC of a req0 op
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.a0 = 32'd10; bus.b0 = 32'd4; bus.sub0 = 1'b1;
        @(negedge clk);
        check("mid_ack0", 64'(bus.ack0), 64'd1);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 32'd100; bus.b1 = 32'd23; bus.sub1 = 1'b0;
        @(negedge clk);
        check("mid_ack1_exec", 64'(bus.ack1), 64'd0);
        @(negedge clk);
        check("mid_ack1_done", 64'(bus.ack1), 64'd0);
        check("mid_done0", 64'(bus.done0), 64'd1);
        check("mid_res0",  64'(bus.result), 64'd6);
        @(negedge clk);
        check("mid_ack1_idle", 64'(bus.ack1), 64'd1);
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_done1", 64'(bus.done1), 64'd1);
        check("mid_res1",  64'(bus.result), 64'd123);

        // Reset during EXEC aborts the op
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.a0 = 32'd7; bus.b0 = 32'd7; bus.sub0 = 1'b0;
        @(negedge clk);
        check("abort_ack0", 64'(bus.ack0), 64'd1);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_done",   64'({bus.done0, bus.done1}), 64'd0);
        check("abort_busy",   64'(bus.busy), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_in1",    64'(bus.dsp_in1), 64'd0);
        check("abort_gnt0",   64'(bus.gnt_cnt0), 64'd0);
        do_op(0, 32'd7, 32'd7, 1'b0, 32'd14, "after_abort");

        // Both requesters held high from reset
        pulse_reset();
        bus.req0 = 1'b1; bus.a0 = 32'd1; bus.b0 = 32'd1; bus.sub0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 32'd2; bus.b1 = 32'd2; bus.sub1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.ack0) begin ack_id.push_back(0); ack_cyc.push_back(i); end
            if (bus.ack1) begin ack_id.push_back(1); ack_cyc.push_back(i); end
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
`ifdef DSP_ARB_RR_EN
        exp_id = '{0, 1, 0, 1};
`else
        exp_id = '{0, 0, 0, 0};
`endif
        check("tie_nacks", 64'(ack_id.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ack_id.size()) begin
                check("tie_id",  64'(ack_id[k]),  64'(exp_id[k]));
                check("tie_cyc", 64'(ack_cyc[k]), 64'(3 * k));
            end
        end
        repeat (3) @(negedge clk);
`ifdef DSP_ARB_RR_EN
        check("tie_gnt0", 64'(bus.gnt_cnt0), 64'd2);
        check("tie_gnt1", 64'(bus.gnt_cnt1), 64'd2);
`else
        check("tie_gnt0", 64'(bus.gnt_cnt0), 64'd4);
        check("tie_gnt1", 64'(bus.gnt_cnt1), 64'd0);
`endif

        // Saturation on the 2-bit counter instance
        nacks = 0;
        @(posedge clk); #1;
        bus2.req0 = 1'b1; bus2.a0 = 32'd9; bus2.b0 = 32'd1; bus2.sub0 = 1'b0;
        for (int i = 0; i < 40 && nacks < 5; i++) begin
            @(negedge clk);
            if (bus2.ack0) nacks++;
        end
        @(posedge clk); #1;
        bus2.req0 = 1'b0;
        repeat (3) @(negedge clk);
        check("sat_nacks", 64'(nacks), 64'd5);
        check("sat_gnt0",  64'(bus2.gnt_cnt0), 64'd3);
        check("sat_gnt1",  64'(bus2.gnt_cnt1), 64'd0);
        check("sat_result", 64'(bus2.result), 64'd10);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
